// File: rtl/icache_rr_arb_slice.sv
// Round-robin arbiter: N_MASTER fetch ports to one downstream target, with a one-entry output buffer.
// Defining ICACHE_ARB_OUT_BYPASS_EN removes the buffer and makes the path combinational.
module icache_rr_arb_slice #(
    parameter int N_MASTER   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = $clog2(N_MASTER)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_MASTER-1:0]            data_req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
    output logic [N_MASTER-1:0]            data_gnt_o,
    output logic                           data_req_o,
    output logic [ADDR_WIDTH-1:0]          data_add_o,
    output logic [ID_WIDTH-1:0]            data_ID_o,
    input  logic                           data_gnt_i,
    output logic [ID_WIDTH-1:0]            rr_ptr_o
);

    localparam int CW = ID_WIDTH + 1;
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(N_MASTER - 1);

    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic                  win_valid;
    logic [ID_WIDTH-1:0]   win_idx;
    logic [ADDR_WIDTH-1:0] win_add;
    logic [CW-1:0]         cand;
    logic                  accept;

    // One spare bit on the candidate index lets ptr+offset exceed N_MASTER before the explicit wrap.
    // NOTE: every always_comb output gets a default first, otherwise paths that skip an assignment infer latches.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(N_MASTER)) cand = cand - CW'(N_MASTER);
            if (!win_valid && data_req_i[cand[ID_WIDTH-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[ID_WIDTH-1:0];
            end
        end
    end

    assign win_add = data_add_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
        data_gnt_o = '0;
        if (accept) data_gnt_o[win_idx] = 1'b1;
    end

    // Explicit wrap so non-power-of-2 port counts never land on an unused index.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) ptr_d = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign rr_ptr_o = ptr_q;

`ifdef ICACHE_ARB_OUT_BYPASS_EN

    assign accept     = win_valid & data_gnt_i;
    assign data_req_o = win_valid;
    assign data_add_o = win_add;
    assign data_ID_o  = win_idx;

`else

    typedef enum logic {EMPTY, FULL} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] buf_add_q, buf_add_d;
    logic [ID_WIDTH-1:0]   buf_id_q, buf_id_d;

    // A new winner can be taken while FULL only when the current entry leaves this cycle.
    assign accept = win_valid & ((state_q == EMPTY) | data_gnt_i);

    always_comb begin
        state_d   = state_q;
        buf_add_d = buf_add_q;
        buf_id_d  = buf_id_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = FULL;
                    buf_add_d = win_add;
                    buf_id_d  = win_idx;
                end
            end
            FULL: begin
                if (data_gnt_i) begin
                    if (accept) begin
                        buf_add_d = win_add;
                        buf_id_d  = win_idx;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: the buffer payload is reset too, because the downstream address and ID must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            buf_add_q <= '0;
            buf_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            buf_add_q <= buf_add_d;
            buf_id_q  <= buf_id_d;
        end
    end

    assign data_req_o = (state_q == FULL);
    assign data_add_o = buf_add_q;
    assign data_ID_o  = buf_id_q;

`endif

endmodule

// File: tb/tb_icache_rr_arb_slice.sv
// Directed bench for icache_rr_arb_slice (registered build): a spec-level model predicts grants and
// pushes each accepted request to a scoreboard that is popped on every downstream handshake.
module tb_icache_rr_arb_slice;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   add;
    logic [N-1:0]      gnt_o;
    logic              req_o;
    logic [AW-1:0]     add_o;
    logic [IW-1:0]     id_o;
    logic              gnt_i;
    logic [IW-1:0]     ptr_o;

    logic [2:0]        req3;
    logic [3*AW-1:0]   add3;
    logic [2:0]        gnt3_o;
    logic              req3_o;
    logic [AW-1:0]     add3_o;
    logic [1:0]        id3_o;
    logic              gnt3_i;
    logic [1:0]        ptr3_o;

    icache_rr_arb_slice #(.N_MASTER(N), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_req_i (req),
        .data_add_i (add),
        .data_gnt_o (gnt_o),
        .data_req_o (req_o),
        .data_add_o (add_o),
        .data_ID_o  (id_o),
        .data_gnt_i (gnt_i),
        .rr_ptr_o   (ptr_o)
    );

    icache_rr_arb_slice #(.N_MASTER(3), .ADDR_WIDTH(AW)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_req_i (req3),
        .data_add_i (add3),
        .data_gnt_o (gnt3_o),
        .data_req_o (req3_o),
        .data_add_o (add3_o),
        .data_ID_o  (id3_o),
        .data_gnt_i (gnt3_i),
        .rr_ptr_o   (ptr3_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
    } txn_t;

    txn_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic          m_full;
    logic [IW-1:0] m_ptr;
    bit            drop_on_grant;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare at the falling edge, advance the model, then let requesters react after the rising edge.
    task automatic tick();
        logic          m_win;
        logic [IW-1:0] m_idx;
        logic          m_acc;
        logic [N-1:0]  m_gnt;
        txn_t          t;
        @(negedge clk);
        m_win = 1'b0;
        m_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!m_win && req[(int'(m_ptr) + i) % N]) begin
                m_win = 1'b1;
                m_idx = IW'((int'(m_ptr) + i) % N);
            end
        end
        m_acc = m_win && (!m_full || gnt_i);
        m_gnt = '0;
        if (m_acc) m_gnt[m_idx] = 1'b1;
        check("gnt_o", 64'(gnt_o), 64'(m_gnt));
        check("req_o", 64'(req_o), 64'(m_full));
        check("rr_ptr", 64'(ptr_o), 64'(m_ptr));
        if (m_full && gnt_i && sb.size() > 0) begin
            t = sb.pop_front();
            check("id_o", 64'(id_o), 64'(t.id));
            check("add_o", 64'(add_o), 64'(t.addr));
        end
        if (m_acc) begin
            t.id   = m_idx;
            t.addr = add[int'(m_idx)*AW +: AW];
            sb.push_back(t);
            m_ptr = (m_idx == IW'(N - 1)) ? '0 : m_idx + 1'b1;
        end
        m_full = m_acc || (m_full && !gnt_i);
        @(posedge clk);
        #1;
        if (m_acc && drop_on_grant) req[m_idx] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; add = '0; gnt_i = 1'b0;
        req3 = '0; add3 = '0; gnt3_i = 1'b0;
        m_full = 1'b0; m_ptr = '0; drop_on_grant = 1'b0;

        #3;
        check("rst_req_o", 64'(req_o), 64'd0);
        check("rst_gnt_o", 64'(gnt_o), 64'd0);
        check("rst_ptr", 64'(ptr_o), 64'd0);
        check("rst_add_o", 64'(add_o), 64'd0);
        check("rst_id_o", 64'(id_o), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset.
        repeat (10) tick();

        // Full contention, downstream always ready.
        for (int k = 0; k < N; k++) add[k*AW +: AW] = AW'(32'h100 * (k + 1));
        req = '1;
        gnt_i = 1'b1;
        repeat (8) tick();
        req = '0;
        tick();

        // Ports 1 and 3 with the pointer at 2.
        drop_on_grant = 1'b1;
        req = 4'b0010;
        tick();
        tick();
        check("t3_ptr_start", 64'(ptr_o), 64'd2);
        req = 4'b1010;
        tick();
        check("t3_ptr_after_p3", 64'(ptr_o), 64'd0);
        check("t3_id_p3", 64'(id_o), 64'd3);
        tick();
        check("t3_ptr_after_p1", 64'(ptr_o), 64'd2);
        check("t3_id_p1", 64'(id_o), 64'd1);
        tick();

        // Backpressure with port 2 buffered while port 0 waits.
        add[2*AW +: AW] = 32'h1000;
        gnt_i = 1'b0;
        req = 4'b0100;
        tick();
        req = 4'b0001;
        repeat (5) begin
            tick();
            check("t4_add_hold", 64'(add_o), 64'h1000);
            check("t4_gnt_none", 64'(gnt_o), 64'd0);
        end
        gnt_i = 1'b1;
        tick();
        check("t4_id_p0", 64'(id_o), 64'd0);
        tick();
        drop_on_grant = 1'b0;
        req = '0;

        // Three-port instance, single requester on the last port.
        add3[2*AW +: AW] = 32'hABC;
        req3 = 3'b100;
        gnt3_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t5_gnt", 64'(gnt3_o), 64'b100);
            check("t5_ptr", 64'(ptr3_o), 64'd0);
            if (c > 0) begin
                check("t5_req_o", 64'(req3_o), 64'd1);
                check("t5_id_o", 64'(id3_o), 64'd2);
                check("t5_add_o", 64'(add3_o), 64'hABC);
            end
            @(posedge clk);
            #1;
        end
        req3 = '0;

        // Reset while the buffer holds a request.
        drop_on_grant = 1'b1;
        gnt_i = 1'b0;
        req = 4'b0010;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_req_o", 64'(req_o), 64'd0);
        check("t6_ptr", 64'(ptr_o), 64'd0);
        check("t6_add_o", 64'(add_o), 64'd0);
        m_full = 1'b0;
        m_ptr = '0;
        sb.delete();
        req = '0;
        drop_on_grant = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/icache_rr_arb_slice.md
Name: icache_rr_arb_slice

Overview:
- N-way round-robin arbitration stage for the icache interconnect.
- Collects fetch requests from N_MASTER ports, picks one winner per cycle with a rotating-priority pointer, and forwards it to a single downstream target.
- The optional one-entry output buffer decouples timing.
- Produces the routing ID that the response path uses to return data to the originating port.

Parameters:
- N_MASTER, 4, number of requesting ports (2..16; need not be a power of 2).
- ADDR_WIDTH, 32, width of each request address.
- ID_WIDTH, $clog2(N_MASTER), width of the winner index / routing ID.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- data_req_i  in  N_MASTER  per-port request.
- data_add_i  in  N_MASTER*ADDR_WIDTH  per-port address; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- data_gnt_o  out  N_MASTER  per-port grant, one-hot or zero.
- data_req_o  out  1  downstream request.
- data_add_o  out  ADDR_WIDTH  downstream address.
- data_ID_o  out  ID_WIDTH  index of the port that owns the downstream request.
- data_gnt_i  in  1  downstream grant.
- rr_ptr_o  out  ID_WIDTH  current round-robin pointer (debug/observability).

Behaviour:
- Reset (async, rst_n=0): rr_ptr=0, buffer EMPTY, data_req_o=0, data_add_o=0, data_ID_o=0, data_gnt_o=0. Reset mid-transaction discards the buffered request without any grant replay.
- Winner selection (combinational): the first k with data_req_i[k]=1, scanning rr_ptr, rr_ptr+1, ..., N_MASTER-1, 0, ..., rr_ptr-1. No request means no winner.
- Accept condition: a winner exists AND (buffer EMPTY OR (data_req_o & data_gnt_i)).
- data_gnt_o[winner]=1 only in the cycle the accept condition holds. All other bits are 0.
- Requester rule: a requester holds data_req_i and data_add_i stable until granted. The block does not check this.
- Pointer update: on accept, rr_ptr <= (winner==N_MASTER-1) ? 0 : winner+1. Wrap is explicit, with no modulo-2^ID_WIDTH wrap for non-power-of-2 N. With no accept, the pointer holds, so there is no toggling when idle.
- Buffer FSM, two states (EMPTY, FULL):
  - EMPTY: on accept, load winner address and ID, go to FULL.
  - FULL, data_gnt_i=1: pop. Same cycle, if the accept condition holds, load the new winner and stay FULL (back-to-back, 1 transfer/cycle). Otherwise go to EMPTY.
  - FULL, data_gnt_i=0: hold. data_req_o, data_add_o and data_ID_o stay stable, and no upstream grant is issued.
- data_req_o = (state==FULL). data_add_o and data_ID_o are driven from the buffer registers.
- Latency: 1 cycle from upstream grant to downstream request.
- Fairness: under continuous contention from all ports, each port is granted exactly once every N_MASTER accepts.
- Single requester: granted every accepted cycle. The pointer follows it (winner+1).

Optional Feature:
- Macro ICACHE_ARB_OUT_BYPASS_EN.
- Defined: the buffer is removed and the path is combinational.
  - data_req_o = winner exists; data_add_o / data_ID_o = winner's address / index.
  - data_gnt_o[winner] = data_gnt_i. rr_ptr updates on data_req_o & data_gnt_i.
  - Latency 0. The downstream may see data_add_o change while data_gnt_i=0 if a higher-priority port raises its request.
- Not defined: registered behaviour as above.

Test Plan:
1. Reset then idle, N_MASTER=4: data_req_i=0 for 10 cycles -> data_req_o=0, data_gnt_o=0, rr_ptr_o=0 throughout.
2. All 4 ports request continuously, data_gnt_i=1 -> grant order 0,1,2,3,0,1; data_ID_o sequence identical, 1 cycle delayed; one data_req_o every cycle after the first.
3. Ports 1 and 3 request, rr_ptr=2 -> port 3 granted first, rr_ptr becomes 0; next, port 1 granted, rr_ptr becomes 2.
4. Backpressure: buffer FULL with port 2 (addr 0x1000), data_gnt_i=0 for 5 cycles while port 0 requests -> data_add_o stays 0x1000, data_gnt_o=0. At data_gnt_i=1, port 0 is granted in that same cycle.
5. N_MASTER=3, only port 2 requests -> rr_ptr wraps to 0, never 3; port 2 is granted every cycle.
6. rst_n asserted while FULL -> data_req_o drops to 0 asynchronously, and rr_ptr_o=0 before the next clk edge. Bypass build: the same stimulus as test 2 gives same-cycle data_gnt_o.
